// File: rtl/systolic_mac_engine.sv
// systolic_mac_engine: shared N x N matrix-multiply / NTAPS-tap FIR engine.
// One input stream, one output stream, mode latched per job at start.
module systolic_mac_engine #(
   parameter int DATA_WIDTH = 32,
   parameter int N          = 4,
   parameter int NTAPS      = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mode,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int KW = $clog2(N);
   localparam int TW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
   localparam logic [KW-1:0] KMAX = KW'(N - 1);
   localparam logic [KW-1:0] KONE = KW'(1);
   localparam logic [TW-1:0] TMAX = TW'(NTAPS - 1);
   localparam logic [TW-1:0] TONE = TW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MM_LOAD,
      S_MM_CALC,
      S_MM_OUT,
      S_FIR_TAPS,
      S_FIR_RUN
   } state_t;

   typedef logic [DATA_WIDTH-1:0] word_t;

   state_t state_q, state_d;

   word_t a_q [N][N];
   word_t a_d [N][N];
   word_t b_q [N][N];
   word_t b_d [N][N];
   word_t c_q [N][N];
   word_t c_d [N][N];

   logic [KW-1:0] ld_r_q, ld_r_d;
   logic [KW-1:0] ld_c_q, ld_c_d;
   logic          ld_b_q, ld_b_d;
   logic [KW-1:0] k_q, k_d;
   logic [KW-1:0] out_r_q, out_r_d;
   logic [KW-1:0] out_c_q, out_c_d;

   word_t taps_q [NTAPS];
   word_t taps_d [NTAPS];
   word_t hist_q [NTAPS];
   word_t hist_d [NTAPS];
   word_t x_new  [NTAPS];

   logic [TW-1:0] tap_cnt_q, tap_cnt_d;
   word_t         fir_out_q, fir_out_d;
   word_t         fir_sum;
   logic          fir_valid_q, fir_valid_d;
   logic          last_q, last_d;
   logic          done_q, done_d;

   logic in_xfer;
   logic out_xfer;

   // Port decode from registered state
   always_comb begin
      in_ready = 1'b0;
      unique case (state_q)
         S_MM_LOAD:  in_ready = 1'b1;
         S_FIR_TAPS: in_ready = 1'b1;
         S_FIR_RUN:  in_ready = (!fir_valid_q | out_ready) & !last_q;
         default:    in_ready = 1'b0;
      endcase
      out_valid = (state_q == S_MM_OUT) | fir_valid_q;
      out_data  = (state_q == S_MM_OUT) ? c_q[out_r_q][out_c_q]
                                        : fir_out_q;
      busy      = (state_q != S_IDLE);
      done      = done_q;
      in_xfer   = in_valid & in_ready;
      out_xfer  = out_valid & out_ready;
   end

   // FIR history after a shift-in and the dot product against the taps
   always_comb begin
      x_new[0] = in_data;
      for (int k = 1; k < NTAPS; k++) begin
         x_new[k] = hist_q[k-1];
      end
      fir_sum = '0;
      for (int k = 0; k < NTAPS; k++) begin
         fir_sum = fir_sum + taps_q[k] * x_new[k];
      end
   end

   // Next-state logic for control and datapath
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      ld_r_d      = ld_r_q;
      ld_c_d      = ld_c_q;
      ld_b_d      = ld_b_q;
      k_d         = k_q;
      out_r_d     = out_r_q;
      out_c_d     = out_c_q;
      taps_d      = taps_q;
      hist_d      = hist_q;
      tap_cnt_d   = tap_cnt_q;
      fir_out_d   = fir_out_q;
      fir_valid_d = fir_valid_q;
      last_d      = last_q;
      done_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start && mode) begin
               state_d     = S_FIR_TAPS;
               tap_cnt_d   = '0;
               fir_valid_d = 1'b0;
               last_d      = 1'b0;
               for (int k = 0; k < NTAPS; k++) begin
                  hist_d[k] = '0;
               end
            end else if (start) begin
               state_d = S_MM_LOAD;
               ld_r_d  = '0;
               ld_c_d  = '0;
               ld_b_d  = 1'b0;
               k_d     = '0;
               out_r_d = '0;
               out_c_d = '0;
               for (int i = 0; i < N; i++) begin
                  for (int j = 0; j < N; j++) begin
                     c_d[i][j] = '0;
                  end
               end
            end
         end

         S_MM_LOAD: begin
            if (in_xfer) begin
               if (ld_b_q) b_d[ld_r_q][ld_c_q] = in_data;
               else        a_d[ld_r_q][ld_c_q] = in_data;
               if (ld_c_q == KMAX) begin
                  ld_c_d = '0;
                  if (ld_r_q == KMAX) begin
                     ld_r_d = '0;
                     ld_b_d = 1'b1;
                     if (ld_b_q) state_d = S_MM_CALC;
                  end else begin
                     ld_r_d = ld_r_q + KONE;
                  end
               end else begin
                  ld_c_d = ld_c_q + KONE;
               end
            end
         end

         S_MM_CALC: begin
            for (int i = 0; i < N; i++) begin
               for (int j = 0; j < N; j++) begin
                  c_d[i][j] = c_q[i][j] + a_q[i][k_q] * b_q[k_q][j];
               end
            end
            if (k_q == KMAX) begin
               k_d     = '0;
               state_d = S_MM_OUT;
            end else begin
               k_d = k_q + KONE;
            end
         end

         S_MM_OUT: begin
            if (out_xfer) begin
               if (out_c_q == KMAX) begin
                  out_c_d = '0;
                  if (out_r_q == KMAX) begin
                     out_r_d = '0;
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     out_r_d = out_r_q + KONE;
                  end
               end else begin
                  out_c_d = out_c_q + KONE;
               end
            end
         end

         S_FIR_TAPS: begin
            if (in_xfer) begin
               taps_d[tap_cnt_q] = in_data;
               if (tap_cnt_q == TMAX) begin
                  tap_cnt_d = '0;
                  state_d   = S_FIR_RUN;
               end else begin
                  tap_cnt_d = tap_cnt_q + TONE;
               end
            end
         end

         S_FIR_RUN: begin
            if (in_xfer) begin
               hist_d      = x_new;
               fir_out_d   = fir_sum;
               fir_valid_d = 1'b1;
               last_d      = in_last;
            end else if (out_xfer) begin
               fir_valid_d = 1'b0;
               if (last_q) begin
                  last_d  = 1'b0;
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, cleared by async reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ld_r_q      <= '0;
         ld_c_q      <= '0;
         ld_b_q      <= 1'b0;
         k_q         <= '0;
         out_r_q     <= '0;
         out_c_q     <= '0;
         tap_cnt_q   <= '0;
         fir_out_q   <= '0;
         fir_valid_q <= 1'b0;
         last_q      <= 1'b0;
         done_q      <= 1'b0;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               a_q[i][j] <= '0;
               b_q[i][j] <= '0;
               c_q[i][j] <= '0;
            end
         end
         for (int k = 0; k < NTAPS; k++) begin
            taps_q[k] <= '0;
            hist_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         ld_r_q      <= ld_r_d;
         ld_c_q      <= ld_c_d;
         ld_b_q      <= ld_b_d;
         k_q         <= k_d;
         out_r_q     <= out_r_d;
         out_c_q     <= out_c_d;
         taps_q      <= taps_d;
         hist_q      <= hist_d;
         tap_cnt_q   <= tap_cnt_d;
         fir_out_q   <= fir_out_d;
         fir_valid_q <= fir_valid_d;
         last_q      <= last_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: doc/systolic_mac_engine.md
# systolic_mac_engine

Parametrised successor to the fixed 4x4 matrix-multiply / 11-tap FIR systolic dataflow block.
- Performs N x N matrix multiplication or NTAPS-tap FIR filtering on a single shared input stream.
- Uses valid/ready handshakes on input and output, with explicit start/done control.
- Sits between the user-project AXI-Stream adapter and the result FIFO; one instance serves both functions, and mode is latched per job.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; all arithmetic modulo 2^DATA_WIDTH
- N, 4, matrix dimension, legal 2..8
- NTAPS, 11, FIR tap count, legal 1..32

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  job start pulse, honoured only in IDLE
- mode  in  1  sampled with start: 0 = matrix multiply, 1 = FIR
- in_data  in  DATA_WIDTH  input word
- in_valid  in  1  input word valid
- in_last  in  1  FIR only: marks final sample of the job
- in_ready  out  1  engine accepts in_data this cycle
- out_data  out  DATA_WIDTH  result word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job completion

## Operation
- Handshakes:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Once out_valid is high, out_data and out_valid hold until the transfer.
- States: IDLE, MM_LOAD, MM_CALC, MM_OUT, FIR_TAPS, FIR_RUN.
- IDLE:
  - in_ready = 0; in_valid is ignored.
  - start & !mode -> MM_LOAD, with all N*N accumulators cleared.
  - start & mode -> FIR_TAPS, with the sample history cleared.
- MM_LOAD:
  - in_ready = 1.
  - Accepts N*N words of A row-major, then N*N words of B row-major.
  - in_last is ignored.
  - After the 2*N*N-th transfer -> MM_CALC.
- MM_CALC:
  - k = 0..N-1, one step per cycle; each step does C[i][j] += A[i][k]*B[k][j] for all i, j in parallel.
  - Exactly N cycles, then -> MM_OUT.
- MM_OUT:
  - out_valid = 1; out_data = C[idx], idx row-major from 0.
  - idx advances on each output transfer.
  - After transfer of idx = N*N-1 -> IDLE, with done pulsed.
- FIR_TAPS:
  - in_ready = 1.
  - Accepts NTAPS words: tap[0] first; tap[0] multiplies the newest sample.
  - After the NTAPS-th transfer -> FIR_RUN.
- FIR_RUN:
  - Each accepted sample shifts into history x[0..NTAPS-1] (x[0] newest).
  - Result: y = sum tap[k]*x[k], history zero-initialised per job.
  - One output per accepted sample.
  - in_ready = !out_valid | out_ready, so a simultaneous output transfer and new input transfer is permitted.
  - A sample accepted with in_last: -> IDLE after its output transfers, with done pulsed.
- Arithmetic: products and sums are truncated to DATA_WIDTH bits; wrap-around, no saturation. Results are bit-identical for signed and unsigned interpretation.
- start outside IDLE is ignored; mode is not re-sampled mid-job.

## Timing
- Reset values: in_ready 0, out_valid 0, out_data 0, busy 0, done 0. State IDLE; accumulators, taps and history all 0.
- rst mid-job aborts immediately. No done is issued, and the next start behaves as after power-up.
- busy rises the cycle after start is sampled.
- MM latency:
  - First out_valid appears N+1 cycles after the final B transfer: N cycles of MM_CALC plus the registered state change.
  - With out_ready held high, one word per cycle.
- FIR latency: out_valid asserts the cycle after a sample transfer, from a registered adder tree. Sustained throughput is 1 sample/cycle with out_ready high.
- done:
  - Asserts for exactly one cycle, the cycle after the final output transfer.
  - busy is already 0 in that cycle.
  - start in that cycle is honoured.
- Backpressure: with out_ready low, in_ready drops in FIR_RUN (once out_valid is high) and in MM_OUT no index advance occurs. No data is lost or duplicated.

## Test plan
- MM identity: defaults, A = identity, B = 1..16 row-major -> out_data 1..16 in order, done one cycle after the 16th transfer, busy low.
- MM uniform: A all 2, B all 3 -> sixteen outputs of 24. First out_valid exactly 5 cycles after the last B transfer.
- MM wrap: A[0][0] = 0x80000000, B[0][0] = 2, all others 0 -> C[0][0] = 0, all outputs 0.
- FIR impulse: taps 1..11, then samples 1 followed by eleven 0s, the last 0 with in_last -> outputs 1,2,...,11,0, then done.
- FIR backpressure: stream 1s with taps all 1; hold out_ready low 5 cycles mid-run -> in_ready low and out_data frozen. The output sequence ramps 1..11, then stays at 11, with no gaps or repeats.
- Control/reset:
  - start pulsed during MM_LOAD is ignored.
  - rst asserted in MM_OUT at idx 7 -> all outputs return to reset values immediately, with no done.
  - A fresh MM identity job afterwards passes.
